array_port_serializer: RTL
==========================

# array_port_serializer

Downstream consumer for modules exposing parameterised unpacked-array output ports (element count and width derived from `TEST`). Captures one whole array frame plus a per-element enable mask in a single handshake. Streams the enabled elements out one per cycle over a valid/ready interface, in ascending index order, tagged with index and last flag. Sits between an array-producing stage and any narrow streaming consumer.

## Interface
Parameters:
- `TEST`, default 6: sizing parameter shared with the upstream stage.
- Derived, not overridable:
  - `N = TEST+2`: element count.
  - `W = TEST+2`: element width.
  - `IW = $clog2(N)`: index width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  frame available.
- `in_ready`  output  1  serializer can accept a frame.
- `in_array`  input  [W-1:0] x [N] unpacked  frame data, element 0 first out.
- `in_mask`  input  1 x [N] unpacked  element enable; 0 means skip the element.
- `out_valid`  output  1  `out_data` holds an element.
- `out_ready`  input  1  consumer accepts the element.
- `out_data`  output  W  element value.
- `out_index`  output  IW  source index of `out_data`.
- `out_last`  output  1  final enabled element of the frame.
- `frame_count`  output  16  frames accepted since reset, wraps.

## Operation
- States: `IDLE`, `SEND`.
- `IDLE`:
  - `in_ready=1`, `out_valid=0`.
  - On `in_valid && in_ready`: latch `in_array` and `in_mask`, and increment `frame_count`.
  - If the mask has any bit set: go to `SEND` with cursor = lowest set index.
  - If the mask is all zero: remain in `IDLE`. No output is produced, but `frame_count` still increments.
- `SEND`:
  - `in_ready=0`, `out_valid=1`.
  - `out_data` = latched element at the cursor; `out_index` = cursor.
  - `out_last=1` when no set mask bit exists above the cursor.
  - On `out_valid && out_ready`:
    - If `out_last`: go to `IDLE`.
    - Else: cursor = next set index above the current cursor.
  - Without `out_ready`: all outputs hold stable (AXI-style; no retraction).
- The latched frame is immutable during `SEND`. `in_array` and `in_mask` are ignored outside the accept cycle.
- `frame_count` is a 16-bit modular increment; 0xFFFF+1 = 0x0000.
- Reset has priority over every event:
  - `rst` high forces `IDLE`, `out_valid=0`, `out_data=0`, `out_index=0`, `out_last=0`, `frame_count=0`, and `in_ready=0`.
  - `in_ready` rises in the first cycle after `rst` deasserts.
  - Reset mid-`SEND` discards the remaining elements.

## Timing
- Registered outputs: `out_*`, `frame_count`, and the state.
- `in_ready` is decoded from state only, with no combinational path from `out_ready` or `in_valid`.
- Latency: frame accepted at edge k gives the first element valid in cycle k+1.
- Throughput: one element per cycle while `out_ready=1`, and masked-off elements cost zero cycles.
- One idle bubble occurs between frames: `in_ready` rises the cycle after the last handshake.
- Peak frame period with full mask is N+1 cycles.
- Empty-mask frame: `in_ready` stays high, so back-to-back empty frames are accepted every cycle.
- A single-bit mask gives one beat with `out_last=1`.

## Structure
- Package `array_port_serializer_pkg`:
  - Holds `N`/`W`/`IW` derivation functions from `TEST`.
  - Holds the state enum `{IDLE, SEND}`.
  - Holds the `frame_count` width constant (16).
- Sub-module `array_mask_next_index`:
  - Combinational priority finder.
  - Inputs: mask [N], cursor, and a `from_start` select.
  - Outputs: next set index strictly above the cursor (or lowest set index when `from_start`), a `found` flag, and a `last` flag (no set bit above the result).
  - Used for both the initial cursor and the advance.

## Test plan
All scenarios use TEST=6, so N=8 and W=8.
- Full mask, `in_array[i]=8'h10+i`, `out_ready=1` → 8 beats `8'h10..8'h17`, indices 0..7, `out_last` only on index 7. `in_ready` is high again 9 cycles after accept, and `frame_count=1`.
- Mask `8'b1010_0100` (bits 2, 5, 7) → beats at indices 2, 5, 7 on consecutive cycles, `out_last` on 7, with no gaps for skipped elements.
- Mask all zero, `in_valid` held 3 cycles → no `out_valid`, `in_ready` stays 1, `frame_count` goes 0→3.
- Full mask with `out_ready` toggling 1,0,0,1,… → `out_data` and `out_index` stable while stalled, and every element delivered exactly once in order.
- `rst` pulsed during `SEND` after 3 beats → next cycle all outputs 0 and `in_ready=0`, then `in_ready=1`. A new frame then streams from its lowest set index.
- Preload by sending 65535 empty frames, then one more → `frame_count` wraps to 0x0000.

Source files
------------

// File: rtl/array_port_serializer_pkg.sv
// Shared sizing helpers, state encoding and counter width for the array port serializer.
// Every dimension derives from the TEST parameter of the upstream array-producing stage.
package array_port_serializer_pkg;

  localparam int FC_W = 16;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t SEND = 1'b1;

  function automatic int calc_n(input int test);
    return test + 2;
  endfunction

  function automatic int calc_w(input int test);
    return test + 2;
  endfunction

  // An index always needs at least one bit, even when the frame holds a single element.
  function automatic int calc_iw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/array_port_serializer_if.sv
// Frame-in / element-out bundle; the slave side is the serializer and the master side is the
// producer/consumer pair. The frame-in handshake is valid/ready and the element-out side is AXI-style.
interface array_port_serializer_if #(
  parameter int TEST = 6
);
  import array_port_serializer_pkg::*;

  localparam int N  = calc_n(TEST);
  localparam int W  = calc_w(TEST);
  localparam int IW = calc_iw(N);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_array [N];
  logic          in_mask  [N];
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_index;
  logic          out_last;

  modport slave (
    input  in_valid, in_array, in_mask, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );

  modport master (
    output in_valid, in_array, in_mask, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );

endinterface

// File: rtl/array_mask_next_index.sv
// Combinational priority finder. It returns the lowest set mask bit, or the lowest set bit above the cursor.
// It has zero latency and no handshake; it serves both frame start and cursor advance.
module array_mask_next_index #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] cursor,
  input  logic          from_start,
  output logic [IW-1:0] idx,
  output logic          found,
  output logic          last
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    last  = 1'b1;
    // Descending scan, so the lowest qualifying bit is the one left standing.
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || i > int'(cursor))) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (found && mask[i] && i > int'(idx)) begin
        last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/array_port_serializer.sv
// Captures an array frame plus an enable mask, then streams the enabled elements in ascending index order.
// The first element appears one cycle after accept. The outputs hold stable while out_ready is low.
module array_port_serializer
  import array_port_serializer_pkg::*;
#(
  parameter int TEST = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  array_port_serializer_if.slave    bus,
  output logic [FC_W-1:0]           frame_count
);

  localparam int N  = calc_n(TEST);
  localparam int W  = calc_w(TEST);
  localparam int IW = calc_iw(N);

  state_t        state;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic [IW-1:0] out_index_q;
  logic          out_last_q;
  logic [FC_W-1:0] frame_count_q;
  logic [W-1:0]  arr_q [N];
  logic [N-1:0]  mask_q;

  logic [N-1:0]  in_mask_p;
  logic [N-1:0]  find_mask;
  logic [IW-1:0] nx_idx;
  logic          nx_found;
  logic          nx_last;
  logic          accept;

  always_comb begin
    in_mask_p = '0;
    for (int i = 0; i < N; i++) begin
      in_mask_p[i] = bus.in_mask[i];
    end
  end

  assign accept    = (state == IDLE) && in_ready_q && bus.in_valid;
  assign find_mask = (state == IDLE) ? in_mask_p : mask_q;

  // out_index doubles as the cursor, so the finder always searches relative to the element on display.
  array_mask_next_index #(
    .N  (N),
    .IW (IW)
  ) u_next (
    .mask       (find_mask),
    .cursor     (out_index_q),
    .from_start (state == IDLE),
    .idx        (nx_idx),
    .found      (nx_found),
    .last       (nx_last)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      arr_q <= bus.in_array;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_index_q   <= '0;
      out_last_q    <= 1'b0;
      frame_count_q <= '0;
      mask_q        <= '0;
    end else if (state == IDLE) begin
      in_ready_q <= 1'b1;
      if (accept) begin
        frame_count_q <= frame_count_q + 16'd1;
        mask_q        <= in_mask_p;
        // An empty mask leaves the block in IDLE, so in_ready stays high for back-to-back frames.
        if (nx_found) begin
          state       <= SEND;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b1;
          out_data_q  <= bus.in_array[nx_idx];
          out_index_q <= nx_idx;
          out_last_q  <= nx_last;
        end
      end
    end else if (bus.out_ready) begin
      if (out_last_q) begin
        state       <= IDLE;
        in_ready_q  <= 1'b1;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        out_data_q  <= arr_q[nx_idx];
        out_index_q <= nx_idx;
        out_last_q  <= nx_last;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;
  assign bus.out_last  = out_last_q;
  assign frame_count   = frame_count_q;

endmodule
